// File: rtl/upscale_pkg.sv
// Shared types and defaults for the upscale feeder.
package upscale_pkg;
  localparam int PIX_W     = 24;
  localparam int DEF_IMG_W = 384;
  localparam int DEF_IMG_H = 216;
  localparam int DEF_SCALE = 3;

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, GAP, DONE} state_t;

  // Counter width for a 0..range-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int range);
    return (range <= 1) ? 1 : $clog2(range);
  endfunction
endpackage

// File: rtl/upscale_line_buf.sv
// One-row line buffer: single port, synchronous read, read data held between reads.
module upscale_line_buf #(
  parameter int DEPTH = 384,
  parameter int WIDTH = 24,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register doubles as the output pixel register, so it holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/upscale_feeder.sv
// Buffers one source row and replays it SCALE times with each pixel held SCALE cycles.
module upscale_feeder #(
  parameter int IMG_W = upscale_pkg::DEF_IMG_W,
  parameter int IMG_H = upscale_pkg::DEF_IMG_H,
  parameter int SCALE = upscale_pkg::DEF_SCALE,
  parameter int PIX_W = upscale_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] src_pixel,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [PIX_W-1:0] pixel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_done
);
  import upscale_pkg::*;

  localparam int CW = cnt_w(IMG_W);
  localparam int PW = cnt_w(SCALE);
  localparam int RW = cnt_w(IMG_H);

  logic [1:0]    rst_sync;
  logic          rst_i_n;
  state_t        state, state_d;
  logic [CW-1:0] col;
  logic [PW-1:0] px_rep, line_rep;
  logic [RW-1:0] row;
  logic          xfer, col_last, px_last, line_last, row_last;

  // Reset asserts immediately, releases synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  assign src_ready = (state == LOAD);
  assign xfer      = src_valid && src_ready;
  assign col_last  = (col == CW'(IMG_W - 1));
  assign px_last   = (px_rep == PW'(SCALE - 1));
  assign line_last = (line_rep == PW'(SCALE - 1));
  assign row_last  = (row == RW'(IMG_H - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state: load a row, replay it SCALE times with a one-cycle gap after each.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (xfer && col_last) state_d = EMIT;
      EMIT: if (col_last && px_last) state_d = GAP;
      GAP: begin
        if (!line_last)     state_d = EMIT;
        else if (!row_last) state_d = LOAD;
        else                state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Position counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      col        <= '0;
      px_rep     <= '0;
      line_rep   <= '0;
      row        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      out_valid  <= (state == EMIT);
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          row      <= '0;
          col      <= '0;
          px_rep   <= '0;
          line_rep <= '0;
        end
        LOAD: if (xfer) col <= col_last ? '0 : col + 1'b1;
        EMIT: begin
          if (px_last) begin
            px_rep <= '0;
            col    <= col_last ? '0 : col + 1'b1;
          end else begin
            px_rep <= px_rep + 1'b1;
          end
        end
        GAP: begin
          if (!line_last) line_rep <= line_rep + 1'b1;
          else if (!row_last) begin
            row      <= row + 1'b1;
            line_rep <= '0;
          end else begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  upscale_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_line_buf (
    .clk   (clk),
    .rst_n (rst_i_n),
    .we    (xfer),
    .re    (state == EMIT),
    .addr  (col),
    .wdata (src_pixel),
    .rdata (pixel_out)
  );
endmodule

// File: tb/tb_upscale_feeder.sv
// Bench for upscale_feeder: randomized frames vs a replication model, plus a cycle table.
module tb_upscale_feeder;
  localparam int W0 = 4, H0 = 2, S0 = 3;
  localparam int W1 = 3, H1 = 1, S1 = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 0, sv0 = 0, sr0, ov0, busy0, fd0;
  logic [23:0] sp0 = '0, po0;
  logic        start1 = 0, sv1 = 0, sr1, ov1, busy1, fd1;
  logic [23:0] sp1 = '0, po1;

  upscale_feeder #(.IMG_W(W0), .IMG_H(H0), .SCALE(S0), .PIX_W(24)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .src_pixel(sp0), .src_valid(sv0),
    .src_ready(sr0), .pixel_out(po0), .out_valid(ov0), .busy(busy0), .frame_done(fd0));

  upscale_feeder #(.IMG_W(W1), .IMG_H(H1), .SCALE(S1), .PIX_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .src_pixel(sp1), .src_valid(sv1),
    .src_ready(sr1), .pixel_out(po1), .out_valid(ov1), .busy(busy1), .frame_done(fd1));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [23:0] pix [W0*H0];
  logic [23:0] exp_q[$], got_q[$];

  // Reference: every row, SCALE replica lines, every pixel SCALE times.
  function automatic void build_exp();
    exp_q.delete();
    for (int r = 0; r < H0; r++)
      for (int lr = 0; lr < S0; lr++)
        for (int c = 0; c < W0; c++)
          for (int p = 0; p < S0; p++)
            exp_q.push_back(pix[r*W0 + c]);
  endfunction

  // Starts a frame on dut0 at the current negedge and drives/monitors it.
  task automatic run_frame(input bit rand_valid, input bit mid_start, input int abort_at,
                           output bit aborted);
    int idx = 0, cyc = 0, run = 0, zrun = 0, last_v = -10, lat_cyc = 0, both = 0;
    bit xfer = 0, lat_pend = 0, fd_seen = 0;
    int runs[$], zruns[$];
    got_q.delete();
    aborted = 0;
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    chk("busy_after_start", busy0, 1);
    chk("src_ready_in_load", sr0, 1);
    while (!fd_seen && cyc < 3000) begin
      if (xfer) idx++;
      if (ov0) begin
        got_q.push_back(po0);
        if (zrun > 0 && runs.size() > 0) zruns.push_back(zrun);
        zrun = 0;
        run++;
        if (lat_pend) begin
          chk("row_to_first_valid_latency", cyc - lat_cyc, 2);
          lat_pend = 0;
        end
        last_v = cyc;
      end else begin
        if (run > 0) runs.push_back(run);
        run = 0;
        if (runs.size() > 0) zrun++;
      end
      if (sr0 && ov0) both++;
      if (fd0) begin
        fd_seen = 1;
        chk("frame_done_after_last_valid", cyc - last_v, 1);
        chk("busy_low_at_frame_done", busy0, 0);
      end
      if (abort_at > 0 && got_q.size() >= abort_at) begin
        aborted = 1;
        break;
      end
      if (idx < W0*H0) begin
        sv0 = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        sp0 = pix[idx];
      end else begin
        sv0 = 1'b0;
      end
      xfer = sv0 && sr0;
      if (xfer && (idx % W0 == W0 - 1)) begin
        lat_pend = 1;
        lat_cyc  = cyc;
      end
      start0 = mid_start && (cyc == 20 || cyc == 50);
      @(negedge clk);
      cyc++;
    end
    sv0 = 0;
    start0 = 0;
    if (!aborted) begin
      chk("frame_completed", fd_seen, 1);
      chk("valid_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        chk($sformatf("pixel[%0d]", i), got_q[i], exp_q[i]);
      chk("replica_line_count", runs.size(), S0*H0);
      foreach (runs[i]) chk($sformatf("line_len[%0d]", i), runs[i], W0*S0);
      chk("gap_segment_count", zruns.size(), S0*H0 - 1);
      foreach (zruns[i]) begin
        if ((i + 1) % S0 != 0) chk($sformatf("gap_len[%0d]", i), zruns[i], 1);
        else chk($sformatf("row_reload_len[%0d]", i), zruns[i] >= W0 + 1, 1);
      end
      chk("ready_with_valid", both, 0);
    end
  endtask

  typedef struct {
    logic        start, sv;
    logic [23:0] sp;
    logic        e_rdy, e_ov;
    logic [23:0] e_px;
    logic        e_busy, e_fd;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[12];
    bit ab;
    // Reset held 10 cycles, then idle with no start.
    repeat (10) @(negedge clk);
    rst_n = 1;
    repeat (8) begin
      @(negedge clk);
      chk("idle_out_valid", {ov0, ov1}, 0);
      chk("idle_pixel_out", po0 | po1, 0);
      chk("idle_src_ready", {sr0, sr1}, 0);
      chk("idle_busy_done", {busy0, busy1, fd0, fd1}, 0);
    end

    // Frame with incrementing pixels and continuous src_valid.
    for (int i = 0; i < W0*H0; i++) pix[i] = 24'(i + 1);
    build_exp();
    run_frame(0, 0, 0, ab);
    // Frame with random data, 50% src_valid and stray starts, one cycle after frame_done.
    chk("frame_done_single_pulse", fd0, 0);
    for (int i = 0; i < W0*H0; i++) pix[i] = 24'($urandom);
    build_exp();
    run_frame(1, 1, 0, ab);
    chk("frame_done_single_pulse2", fd0, 0);
    chk("busy_low_after_frame", busy0, 0);

    // Reset during the second replica line of row 0.
    repeat (3) @(negedge clk);
    run_frame(1, 0, W0*S0 + 5, ab);
    chk("aborted_in_line2", ab, 1);
    rst_n = 0;
    #1;
    chk("rst_pixel_out", po0, 0);
    chk("rst_out_valid", ov0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_src_ready", sr0, 0);
    chk("rst_frame_done", fd0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < W0*H0; i++) pix[i] = 24'($urandom);
    build_exp();
    run_frame(1, 0, 0, ab);

    // SCALE=1 cycle table: expected outputs at this negedge, then inputs for the next edge.
    tbl[0]  = '{1, 0, 24'h0,      0, 0, 24'h0,      0, 0};
    tbl[1]  = '{0, 0, 24'h0,      1, 0, 24'h0,      1, 0};
    tbl[2]  = '{0, 1, 24'hAA0000, 1, 0, 24'h0,      1, 0};
    tbl[3]  = '{0, 1, 24'h00BB00, 1, 0, 24'h0,      1, 0};
    tbl[4]  = '{0, 1, 24'h0000CC, 1, 0, 24'h0,      1, 0};
    tbl[5]  = '{0, 0, 24'h0,      0, 0, 24'h0,      1, 0};
    tbl[6]  = '{0, 0, 24'h0,      0, 1, 24'hAA0000, 1, 0};
    tbl[7]  = '{0, 0, 24'h0,      0, 1, 24'h00BB00, 1, 0};
    tbl[8]  = '{0, 0, 24'h0,      0, 1, 24'h0000CC, 1, 0};
    tbl[9]  = '{1, 0, 24'h0,      0, 0, 24'h0000CC, 0, 1};
    tbl[10] = '{0, 0, 24'h0,      0, 0, 24'h0000CC, 0, 0};
    tbl[11] = '{0, 0, 24'h0,      0, 0, 24'h0000CC, 0, 0};
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("tbl%0d_src_ready", i), sr1, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_out_valid", i), ov1, tbl[i].e_ov);
      chk($sformatf("tbl%0d_pixel_out", i), po1, tbl[i].e_px);
      chk($sformatf("tbl%0d_busy", i), busy1, tbl[i].e_busy);
      chk($sformatf("tbl%0d_frame_done", i), fd1, tbl[i].e_fd);
      start1 = tbl[i].start;
      sv1    = tbl[i].sv;
      sp1    = tbl[i].sp;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
